// File: rtl/lzd_pkg.sv
// Shared constants for the sequential leading-zero normalizer:
// FSM state encodings and a constant-foldable ceil(log2) helper.
`timescale 1ns/1ps
package lzd_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/lzd_chunk.sv
// Combinational leading-zero detector for one W-bit chunk, built as a
// recursive tree of 2-bit cells merged with the (position, valid) combine.
`timescale 1ns/1ps
module lzd_chunk
  import lzd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]        d,
  output logic [clog2(W)-1:0] z,
  output logic                nz
);

  generate
    if (W == 2) begin : g_leaf
      assign z  = ~d[1];
      assign nz = |d;
    end else begin : g_node
      localparam int HW  = W / 2;
      localparam int SZW = clog2(HW);

      logic [SZW-1:0] z_hi;
      logic [SZW-1:0] z_lo;
      logic           nz_hi;
      logic           nz_lo;

      lzd_chunk #(.W(HW)) u_hi (.d(d[W-1:HW]), .z(z_hi), .nz(nz_hi));
      lzd_chunk #(.W(HW)) u_lo (.d(d[HW-1:0]), .z(z_lo), .nz(nz_lo));

      // Upper half wins when it holds a one; otherwise the lower position
      // is offset by HW, which is just the new MSB of z.
      assign nz = nz_hi | nz_lo;
      assign z  = nz_hi ? {1'b0, z_hi} : {1'b1, z_lo};
    end
  endgenerate

endmodule

// File: rtl/lzd_seq_norm_ctrl.sv
// Multi-cycle leading-zero counter and normalizer: scans the operand
// MSB-first one chunk per cycle with a single shared chunk LZD.
`timescale 1ns/1ps
module lzd_seq_norm_ctrl
  import lzd_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int CHUNK_WIDTH = 8,
  localparam int CNT_WIDTH   = clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic [DATA_WIDTH-1:0] out_norm,
  output logic                  out_zero
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam int ZW     = clog2(CHUNK_WIDTH);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic                  zero_q,  zero_d;

  logic [ZW-1:0]         chunk_z;
  logic                  chunk_nz;

  lzd_chunk #(.W(CHUNK_WIDTH)) u_lzd_chunk (
    .d  (data_q[DATA_WIDTH-1 -: CHUNK_WIDTH]),
    .z  (chunk_z),
    .nz (chunk_nz)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    zero_d  = zero_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d  = in_data;
            cnt_d   = '0;
            idx_d   = '0;
            zero_d  = 1'b0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (chunk_nz) begin
            cnt_d   = cnt_q + CNT_WIDTH'(chunk_z);
            data_d  = data_q << chunk_z;
            state_d = DONE;
          end else if (idx_q == IDX_W'(NCHUNK - 1)) begin
            cnt_d   = cnt_q + CNT_WIDTH'(CHUNK_WIDTH);
            data_d  = '0;
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_WIDTH'(CHUNK_WIDTH);
            data_d  = data_q << CHUNK_WIDTH;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_count = cnt_q;
  assign out_norm  = data_q;
  assign out_zero  = zero_q;

endmodule
